// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-entry issue stage between decode and the FPU.
// Accepts one FP request, resolves the rounding mode, drives the FPU operand,
// select and enable inputs for the op latency (extended while fpu_stall is
// high), stalls the integer pipeline and returns the result with its tag.
//
// Optional build macro: FPU_TIMEOUT_EN
//   When defined, a watchdog counts EXEC cycles; if the FPU is still stalling
//   after TIMEOUT cycles the op is retired as illegal with a canonical NaN.
//   When undefined, EXEC waits on fpu_stall indefinitely.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; decode and latch on req_valid
// EXEC   | FPU op in flight; latency counter running / waiting on fpu_stall
// RESP   | response held on rsp_* until the writeback handshake
module fpu_issue_ctrl #(
    parameter int XLEN     = 32,
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 3,
    parameter int SQRT_LAT = 12,
    parameter int DIV_LAT  = 12,
    parameter int TIMEOUT  = 64
) (
    input  logic            g_clk,
    input  logic            g_rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [XLEN-1:0] req_c,
    input  logic [4:0]      req_sel_s,
    input  logic [4:0]      req_sel_d,
    input  logic [2:0]      req_frm,
    input  logic [2:0]      sys_rm,
    input  logic [4:0]      req_rd,
    output logic [XLEN-1:0] fpu_a,
    output logic [XLEN-1:0] fpu_b,
    output logic [XLEN-1:0] fpu_c,
    output logic [2:0]      fpu_frm,
    output logic [4:0]      fpu_sel_s,
    output logic [4:0]      fpu_sel_d,
    output logic            fpu_enable,
    input  logic [XLEN-1:0] fpu_res,
    input  logic            fpu_stall,
    output logic            stall,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_illegal
);

    localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int MAX_SD  = (SQRT_LAT > DIV_LAT) ? SQRT_LAT : DIV_LAT;
    localparam int MAX_LAT = (MAX_AM > MAX_SD) ? MAX_AM : MAX_SD;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [XLEN-1:0] CANON_NAN = XLEN'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lat_m1;
    logic [2:0]       w_rm;
    logic             w_rm_bad;
    logic             w_sel_ok;
    logic             w_illegal;
    logic             w_accept;
    logic             w_done;
    logic             w_timeout;

    logic [XLEN-1:0]  r_fpu_a;
    logic [XLEN-1:0]  r_fpu_b;
    logic [XLEN-1:0]  r_fpu_c;
    logic [2:0]       r_fpu_frm;
    logic [4:0]       r_fpu_sel_s;
    logic [4:0]       r_fpu_sel_d;
    logic             r_fpu_enable;
    logic [XLEN-1:0]  r_rsp_data;
    logic [4:0]       r_rsp_rd;
    logic             r_rsp_illegal;

    // Rounding-mode resolution and legality decode of the incoming request.
    assign w_rm      = (req_frm == 3'b111) ? sys_rm : req_frm;
    assign w_rm_bad  = (w_rm == 3'b101) || (w_rm == 3'b110) || (w_rm == 3'b111);
    assign w_sel_ok  = (req_sel_s == 5'd0) || (req_sel_s == 5'd1) || (req_sel_s == 5'd2) ||
                       (req_sel_s == 5'd4) || (req_sel_s == 5'd8);
    assign w_illegal = w_rm_bad || !w_sel_ok;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_done    = (r_state == S_EXEC) && (r_cnt == '0) && !fpu_stall;

    // Latency-minus-one for the requested op; counter reaches zero on the last cycle.
    always_comb begin
        w_lat_m1 = '0;
        case (req_sel_s)
            5'd0, 5'd1: w_lat_m1 = CNT_W'(ADD_LAT - 1);
            5'd2:       w_lat_m1 = CNT_W'(MUL_LAT - 1);
            5'd4:       w_lat_m1 = CNT_W'(SQRT_LAT - 1);
            5'd8:       w_lat_m1 = CNT_W'(DIV_LAT - 1);
            default:    w_lat_m1 = '0;
        endcase
    end

`ifdef FPU_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] r_wait;

    // Watchdog fires at the end of the TIMEOUT-th EXEC cycle if the FPU still stalls.
    assign w_timeout = (r_state == S_EXEC) && fpu_stall && (r_wait == WAIT_W'(TIMEOUT - 1));

    // EXEC cycle counter for the watchdog, restarted on every accept.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= '0;
        end else if ((r_state == S_EXEC) && !w_timeout) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    // State register.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; illegal requests skip EXEC and respond immediately.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_illegal ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand/select capture, latency countdown and response capture.
    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            r_fpu_a       <= '0;
            r_fpu_b       <= '0;
            r_fpu_c       <= '0;
            r_fpu_frm     <= '0;
            r_fpu_sel_s   <= '0;
            r_fpu_sel_d   <= '0;
            r_fpu_enable  <= 1'b0;
            r_cnt         <= '0;
            r_rsp_data    <= '0;
            r_rsp_rd      <= '0;
            r_rsp_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rsp_rd <= req_rd;
            if (w_illegal) begin
                r_rsp_data    <= '0;
                r_rsp_illegal <= 1'b1;
            end else begin
                r_fpu_a       <= req_a;
                r_fpu_b       <= req_b;
                r_fpu_c       <= req_c;
                r_fpu_frm     <= w_rm;
                r_fpu_sel_s   <= req_sel_s;
                r_fpu_sel_d   <= req_sel_d;
                r_fpu_enable  <= 1'b1;
                r_cnt         <= w_lat_m1;
                r_rsp_illegal <= 1'b0;
            end
        end else if (r_state == S_EXEC) begin
            if (w_done) begin
                r_rsp_data    <= fpu_res;
                r_rsp_illegal <= 1'b0;
                r_fpu_enable  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data    <= CANON_NAN;
                r_rsp_illegal <= 1'b1;
                r_fpu_enable  <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign stall       = (r_state != S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);

    assign fpu_a       = r_fpu_a;
    assign fpu_b       = r_fpu_b;
    assign fpu_c       = r_fpu_c;
    assign fpu_frm     = r_fpu_frm;
    assign fpu_sel_s   = r_fpu_sel_s;
    assign fpu_sel_d   = r_fpu_sel_d;
    assign fpu_enable  = r_fpu_enable;
    assign rsp_data    = r_rsp_data;
    assign rsp_rd      = r_rsp_rd;
    assign rsp_illegal = r_rsp_illegal;

endmodule
